// File: rtl/jk_sync_counter_if.sv
// Bus bundle for jk_sync_counter: control inputs, count outputs and the
// per-bit JK drive observation outputs.
interface jk_sync_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             tc;
  logic [WIDTH-1:0] j_drv;
  logic [WIDTH-1:0] k_drv;

  modport master (
    output en, up_dn, load, d_in,
    input  q, q_bar, tc, j_drv, k_drv
  );

  modport slave (
    input  en, up_dn, load, d_in,
    output q, q_bar, tc, j_drv, k_drv
  );
endinterface

// File: rtl/jk_sync_counter.sv
// Synchronous modulo-MODULUS up/down counter made of WIDTH JK cells.
// The J/K drive for every bit is derived here each cycle and the state is
// updated only through the JK characteristic equation.
module jk_sync_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input logic               clk,
  input logic               rst_n,
  jk_sync_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

  generate
    if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_param_chk
      $error("jk_sync_counter: illegal WIDTH/MODULUS combination");
    end
  endgenerate

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] j_drv;
  logic [WIDTH-1:0] k_drv;
  logic [WIDTH-1:0] tgl_up;
  logic [WIDTH-1:0] tgl_dn;
  logic [WIDTH-1:0] d_eff;
  logic             carry_up;
  logic             carry_dn;
  logic             tc;

  // Toggle masks: bit i toggles when all lower bits are ones (up) or zeros (down).
  always_comb begin
    tgl_up   = '0;
    tgl_dn   = '0;
    carry_up = 1'b1;
    carry_dn = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      tgl_up[i] = carry_up;
      tgl_dn[i] = carry_dn;
      carry_up  = carry_up & q_q[i];
      carry_dn  = carry_dn & ~q_q[i];
    end
  end

  // J/K drive selection in priority order: reset, load, count, hold.
  always_comb begin
    j_drv = '0;
    k_drv = '0;
    d_eff = (bus.d_in <= CNT_MAX) ? bus.d_in : CNT_MAX;
    if (!rst_n) begin
      k_drv = '1;
    end else if (bus.load) begin
      j_drv = d_eff;
      k_drv = ~d_eff;
    end else if (bus.en) begin
      if (q_q > CNT_MAX) begin
        k_drv = '1;
      end else if (bus.up_dn) begin
        if (q_q == CNT_MAX) begin
          k_drv = '1;
        end else begin
          j_drv = tgl_up;
          k_drv = tgl_up;
        end
      end else begin
        if (q_q == '0) begin
          j_drv = CNT_MAX;
          k_drv = ~CNT_MAX;
        end else begin
          j_drv = tgl_dn;
          k_drv = tgl_dn;
        end
      end
    end
  end

  // JK characteristic equation and terminal count.
  always_comb begin
    q_d = (j_drv & ~q_q) | (~k_drv & q_q);
    tc  = rst_n & bus.en & ~bus.load &
          ((bus.up_dn & (q_q == CNT_MAX)) | (~bus.up_dn & (q_q == '0)));
  end

  // State register; the reset branch yields the same value the JK drive produces.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.q_bar = ~q_q;
  assign bus.tc    = tc;
  assign bus.j_drv = j_drv;
  assign bus.k_drv = k_drv;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Self-checking bench: two counters (MODULUS 10 and 16) driven with the same
// directed stimulus, checked every cycle against an arithmetic model plus
// hand-computed literal expectations.
module tb_jk_sync_counter;

  localparam int W   = 4;
  localparam int MSK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic en_v, up_v, ld_v;
  logic [W-1:0] d_v;

  int checks = 0;
  int errors = 0;
  int mods [2] = '{10, 16};
  int m_q [2];
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  jk_sync_counter_if #(.WIDTH(W)) ifa ();
  jk_sync_counter_if #(.WIDTH(W)) ifb ();

  assign ifa.en = en_v;  assign ifa.up_dn = up_v;  assign ifa.load = ld_v;  assign ifa.d_in = d_v;
  assign ifb.en = en_v;  assign ifb.up_dn = up_v;  assign ifb.load = ld_v;  assign ifb.d_in = d_v;

  jk_sync_counter #(.WIDTH(W), .MODULUS(10)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  jk_sync_counter #(.WIDTH(W), .MODULUS(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Next value as integer arithmetic; drives follow from it: a forced value
  // gives j=next, k=~next, a plain step gives j=k=q^next.
  task automatic model(input int q, input int md, input bit rst, input bit en,
                       input bit up, input bit ld, input int d,
                       output int nq, output int j, output int k, output int tc);
    bit forced;
    forced = 1'b0;
    nq = q; j = 0; k = 0; tc = 0;
    if (!rst) begin
      nq = 0; forced = 1'b1;
    end else if (ld) begin
      nq = (d < md) ? d : md - 1; forced = 1'b1;
    end else if (en) begin
      if (q >= md) begin
        nq = 0; forced = 1'b1;
      end else if (up) begin
        if (q == md - 1) begin nq = 0; tc = 1; forced = 1'b1; end
        else begin nq = q + 1; j = q ^ nq; k = j; end
      end else begin
        if (q == 0) begin nq = md - 1; tc = 1; forced = 1'b1; end
        else begin nq = q - 1; j = q ^ nq; k = j; end
      end
    end
    if (forced) begin
      j = nq;
      k = ~nq & MSK;
    end
  endtask

  // Model state advances on every rising edge once a reset edge has been seen.
  always @(posedge clk) begin
    int nq, j, k, tc;
    for (int i = 0; i < 2; i++) begin
      model(m_q[i], mods[i], rst_n, en_v, up_v, ld_v, int'(d_v), nq, j, k, tc);
      m_q[i] = nq;
    end
    if (!rst_n) m_valid = 1'b1;
  end

  // Per-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    int nq, j, k, tc;
    if (m_valid) begin
      model(m_q[0], mods[0], rst_n, en_v, up_v, ld_v, int'(d_v), nq, j, k, tc);
      chk("A.q",     int'(ifa.q),     m_q[0]);
      chk("A.q_bar", int'(ifa.q_bar), ~m_q[0] & MSK);
      chk("A.tc",    int'(ifa.tc),    tc);
      chk("A.j_drv", int'(ifa.j_drv), j);
      chk("A.k_drv", int'(ifa.k_drv), k);
      model(m_q[1], mods[1], rst_n, en_v, up_v, ld_v, int'(d_v), nq, j, k, tc);
      chk("B.q",     int'(ifb.q),     m_q[1]);
      chk("B.q_bar", int'(ifb.q_bar), ~m_q[1] & MSK);
      chk("B.tc",    int'(ifb.tc),    tc);
      chk("B.j_drv", int'(ifb.j_drv), j);
      chk("B.k_drv", int'(ifb.k_drv), k);
    end
  end

  task automatic drive(input bit rst, input bit en, input bit up, input bit ld, input int d);
    rst_n = rst; en_v = en; up_v = up; ld_v = ld; d_v = W'(d);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 1, 1, 0, 0);
    // Reset for two edges with en=1, up=1.
    step(); step();
    chk("rst A.q", int'(ifa.q), 0);
    chk("rst A.q_bar", int'(ifa.q_bar), 15);
    chk("rst A.k_drv", int'(ifa.k_drv), 15);
    chk("rst A.j_drv", int'(ifa.j_drv), 0);
    chk("rst A.tc", int'(ifa.tc), 0);
    chk("rst B.q", int'(ifb.q), 0);

    // Release and count up: 1, 2, 3.
    drive(1, 1, 1, 0, 0);
    step(); chk("up1 A.q", int'(ifa.q), 1);
    step(); chk("up2 A.q", int'(ifa.q), 2);
    step(); chk("up3 A.q", int'(ifa.q), 3);
    repeat (6) step();
    chk("up9 A.q", int'(ifa.q), 9);
    chk("up9 A.tc", int'(ifa.tc), 1);
    chk("up9 A.j_drv", int'(ifa.j_drv), 0);
    chk("up9 A.k_drv", int'(ifa.k_drv), 15);
    chk("up9 B.tc", int'(ifb.tc), 0);
    chk("up9 B.j_drv", int'(ifb.j_drv), 3);
    chk("model up9 A", m_q[0], 9);
    step();
    chk("wrap A.q", int'(ifa.q), 0);
    chk("wrap B.q", int'(ifb.q), 10);
    chk("model wrap B", m_q[1], 10);

    // Load 0, then count down through the wrap.
    drive(1, 0, 0, 1, 0); step();
    drive(1, 1, 0, 0, 0);
    chk("dn0 A.tc", int'(ifa.tc), 1);
    chk("dn0 A.j_drv", int'(ifa.j_drv), 4'b1001);
    chk("dn0 A.k_drv", int'(ifa.k_drv), 4'b0110);
    chk("dn0 B.j_drv", int'(ifb.j_drv), 4'b1111);
    chk("dn0 B.k_drv", int'(ifb.k_drv), 4'b0000);
    step();
    chk("dnwrap A.q", int'(ifa.q), 9);
    chk("dnwrap B.q", int'(ifb.q), 15);
    chk("dnwrap A.tc", int'(ifa.tc), 0);
    step();
    chk("dn8 A.q", int'(ifa.q), 8);
    chk("model dn8 A", m_q[0], 8);

    // Load priority and clamp.
    drive(1, 0, 1, 1, 3); step();
    chk("ld3 A.q", int'(ifa.q), 3);
    drive(1, 1, 1, 1, 12);
    chk("ld12 A.tc", int'(ifa.tc), 0);
    chk("ld12 A.j_drv", int'(ifa.j_drv), 9);
    step();
    chk("clamp A.q", int'(ifa.q), 9);
    chk("noclamp B.q", int'(ifb.q), 12);
    drive(1, 1, 1, 1, 5); step();
    chk("ld5 A.q", int'(ifa.q), 5);

    // Toggle pattern from 0111 and hold.
    drive(1, 0, 1, 1, 7); step();
    drive(1, 1, 1, 0, 0);
    chk("tgl A.j_drv", int'(ifa.j_drv), 15);
    chk("tgl A.k_drv", int'(ifa.k_drv), 15);
    chk("tgl B.j_drv", int'(ifb.j_drv), 15);
    step();
    chk("tgl A.q", int'(ifa.q), 8);
    drive(1, 0, 1, 0, 0);
    chk("hold A.j_drv", int'(ifa.j_drv), 0);
    chk("hold A.k_drv", int'(ifa.k_drv), 0);
    repeat (3) step();
    chk("hold A.q", int'(ifa.q), 8);
    chk("hold B.q", int'(ifb.q), 8);

    // Mid-operation reset beats load.
    drive(1, 0, 1, 1, 6); step();
    chk("ld6 A.q", int'(ifa.q), 6);
    drive(0, 1, 1, 1, 2);
    chk("mrst A.tc", int'(ifa.tc), 0);
    chk("mrst A.k_drv", int'(ifa.k_drv), 15);
    step();
    chk("mrst A.q", int'(ifa.q), 0);
    drive(1, 1, 1, 0, 0); step();
    chk("resume A.q", int'(ifa.q), 1);

    // Full-range wrap on the MODULUS=16 counter.
    drive(1, 0, 1, 1, 15); step();
    drive(1, 1, 1, 0, 0);
    chk("b15 B.tc", int'(ifb.tc), 1);
    chk("b15 A.q", int'(ifa.q), 9);
    step();
    chk("b15wrap B.q", int'(ifb.q), 0);
    chk("b15wrap A.q", int'(ifa.q), 0);

    // Direction changing every edge.
    drive(1, 1, 0, 0, 0); step();
    chk("alt A.q", int'(ifa.q), 9);
    drive(1, 1, 1, 0, 0); step();
    chk("alt2 A.q", int'(ifa.q), 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_sync_counter.md
# jk_sync_counter

Synchronous modulo-N up/down counter built from WIDTH JK storage cells, one per bit. It is the stage directly downstream of the single JK flip-flop: each bit's J/K drive is generated here and applied through the JK characteristic equation. It is the first multi-bit sequential block in the latches & flip-flops → counters progression. It provides load, enable, direction control and a terminal-count output for cascading.

## Interface
- WIDTH, 4: number of JK cells / counter bits (2..16).
- MODULUS, 16: count range 0..MODULUS-1; legal range 2..2^WIDTH.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- en  input  1  count enable; 1 = advance one step this edge.
- up_dn  input  1  direction; 1 = up, 0 = down.
- load  input  1  parallel load request; overrides en.
- d_in  input  WIDTH  parallel load value.
- q  output  WIDTH  registered count.
- q_bar  output  WIDTH  bitwise complement of q, always ~q.
- tc  output  1  terminal count, combinational; 1 when the next enabled step wraps.
- j_drv  output  WIDTH  per-bit J drive applied at the coming edge (observation).
- k_drv  output  WIDTH  per-bit K drive applied at the coming edge (observation).

## Operation
- Storage: each bit updates as q[i]+ = (j_drv[i] & ~q[i]) | (~k_drv[i] & q[i]). No other path writes q.
- Priority per edge: rst_n=0 > load=1 > en=1 > hold.
- Reset (rst_n=0): j_drv=0 and k_drv=all ones, so q clears to 0.
- Load: j_drv=d_eff and k_drv=~d_eff.
  - d_eff = d_in when d_in < MODULUS; otherwise d_eff = MODULUS-1 (clamp).
- Hold (en=0, load=0): j_drv=k_drv=0, q unchanged.
- Count up, q < MODULUS-1: bit i toggles (j=k=1) iff q[i-1:0] is all ones; bit 0 always toggles. Other bits get j=k=0.
- Count up, q == MODULUS-1: wrap to 0 with j_drv=0 and k_drv=all ones.
- Count down, q > 0: bit i toggles iff q[i-1:0] is all zeros; bit 0 always toggles.
- Count down, q == 0: wrap to MODULUS-1 with j_drv=MODULUS-1 and k_drv=~(MODULUS-1).
- Out-of-range state (q ≥ MODULUS, reachable only via X/corruption): the next enabled step forces q to 0, same drive as reset.
- tc = rst_n & en & ~load & ((up_dn & q==MODULUS-1) | (~up_dn & q==0)).
- Width rules: all compares are unsigned at WIDTH bits. MODULUS-1 must fit in WIDTH; an elaboration-time check fails otherwise.

## Timing
- Reset values after the first edge with rst_n=0: q=0, q_bar=all ones. While rst_n=0: tc=0, j_drv=0, k_drv=all ones.
- Reset is synchronous: an rst_n pulse between edges has no effect on q. Reset asserted mid-count clears q at the next edge regardless of en, load or up_dn.
- Latency: a load or step is visible on q one edge after the inputs are sampled.
- tc, j_drv and k_drv are combinational from q and the current inputs; they are valid before the edge they control.
- tc is high for exactly the cycle in which the wrapping step is taken. Cascade convention: the next stage's en = tc.
- up_dn may change every cycle; each edge uses the direction sampled at that edge. No hysteresis.
- load and en asserted together: load wins, no count that cycle, tc=0.

## Test plan
- Reset: rst_n=0 for 2 edges with en=1, up_dn=1 → q=0, q_bar=4'hF, k_drv=4'hF, tc=0. Release → q counts 1, 2, 3 on the following edges.
- Up wrap, MODULUS=10: from q=0 with en=1, up_dn=1 for 10 edges → q=1..9, then 0. tc=1 only while q=9. At q=9 the drive is j_drv=0, k_drv=4'hF.
- Down wrap, MODULUS=10: load 0, then up_dn=0, en=1 → tc=1 at q=0; next edge q=9 with j_drv=4'b1001, k_drv=4'b0110. Then q=8.
- Load priority and clamp: q=3, load=1, en=1, d_in=4'd12 with MODULUS=10 → q=9 next edge, tc=0 during the load cycle. Repeat with d_in=5 → q=5.
- Hold and toggle pattern, MODULUS=16: at q=4'b0111 with en=1, up → j_drv=k_drv=4'b1111 and q=4'b1000. With en=0 → j_drv=k_drv=0 and q stays 4'b1000 for 3 edges.
- Mid-operation reset: counting up at q=6, drop rst_n for one cycle with load=1, d_in=2 → q=0 (not 2). Counting resumes from 0.
